// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder from two half adders and an OR.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  halfAdder1b u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  halfAdder1b u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/halfAdder1b.sv
// One-bit half adder: sum and carry of two inputs.
module halfAdder1b (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder controller, LSB first, one full-adder cell.
// Define SERIAL_SUB_EN to add the sub port (A-B via ~B and carry-in 1).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
`ifdef SERIAL_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Cout
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;

  logic fa_s;
  logic fa_co;
  logic [N-1:0] b_in;
  logic cin0;

`ifdef SERIAL_SUB_EN
  assign b_in = sub ? ~B : B;
  assign cin0 = sub;
`else
  assign b_in = B;
  assign cin0 = 1'b0;
`endif

  full_adder_1b u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = b_in;
          carry_d = cin0;
          cnt_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Sum bits enter at the MSB so bit 0 lands at S[0] after N shifts.
        s_d     = {fa_s, s_q[N-1:1]};
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    S    = s_q;
    Cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at N=4.
module tb_serial_adder_ctrl;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] S;
  logic         Cout;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif

  int n_run  = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // start one cycle, check per-cycle busy/done, then the result
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic sb, input logic [N:0] exp);
    @(negedge clock);
    A = a;
    B = b;
`ifdef SERIAL_SUB_EN
    sub = sb;
`else
    if (sb) $display("note: sub ignored in add-only build");
`endif
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("op_busy", busy, 1'b1);
      check("op_nodone", done, 1'b0);
      @(negedge clock);
    end
    check("op_done", done, 1'b1);
    check("op_busy0", busy, 1'b0);
    check("op_res", {Cout, S}, exp);
    @(negedge clock);
    check("op_done0", done, 1'b0);
    check("op_hold", {Cout, S}, exp);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] r;
  } vec_t;

  vec_t vecs[5] = '{
    '{4'd5,  4'd3,  5'b0_1000},
    '{4'd15, 4'd1,  5'b1_0000},
    '{4'd15, 4'd15, 5'b1_1110},
    '{4'd9,  4'd6,  5'b0_1111},
    '{4'd0,  4'd0,  5'b0_0000}
  };

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", {Cout, S}, 5'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", busy, 1'b0);

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].r);

    // start held through RUN, operands changed mid-op
    @(negedge clock);
    A = 4'd5;
    B = 4'd3;
    start = 1'b1;
    @(negedge clock);
    check("hold_busy", busy, 1'b1);
    @(negedge clock);
    A = 4'd2;
    B = 4'd7;
    check("hold_busy", busy, 1'b1);
    repeat (N - 2) begin
      @(negedge clock);
      check("hold_busy", busy, 1'b1);
    end
    @(negedge clock);
    check("hold_done", done, 1'b1);
    check("hold_res", {Cout, S}, 5'd8);
    @(negedge clock);
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    check("b2b_done0", done, 1'b0);
    repeat (N - 1) begin
      @(negedge clock);
      check("b2b_busy", busy, 1'b1);
    end
    @(negedge clock);
    check("b2b_done", done, 1'b1);
    check("b2b_res", {Cout, S}, 5'd9);
    @(negedge clock);
    check("b2b_idle", busy, 1'b0);

    // reset two cycles into RUN
    A = 4'd15;
    B = 4'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("abort_busy", busy, 1'b1);
    @(negedge clock);
    check("abort_part", S, 4'b1000);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy0", busy, 1'b0);
    check("abort_done0", done, 1'b0);
    check("abort_res", {Cout, S}, 5'd0);
    repeat (N + 2) begin
      @(negedge clock);
      check("abort_nodone", done, 1'b0);
      check("abort_idle", busy, 1'b0);
    end

    // reset and start together
    A = 4'd3;
    B = 4'd4;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    check("rs_busy", busy, 1'b0);
    check("rs_done", done, 1'b0);
    @(negedge clock);
    check("rs_busy2", busy, 1'b0);

`ifdef SERIAL_SUB_EN
    do_op(4'd3, 4'd5, 1'b1, 5'b0_1110);
    do_op(4'd5, 4'd3, 1'b1, 5'b1_0010);
`endif

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b), 1'b0, 5'(a + b));
`ifdef SERIAL_SUB_EN
        do_op(4'(a), 4'(b), 1'b1, 5'(a + (15 - b) + 1));
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
